// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_ctrl_pkg: state encodings and shared constants for the stopwatch front panel
package stopwatch_ctrl_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;
  localparam int DEBOUNCE_DEFAULT = 250000;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce: 2-flop sync, stable-count debounce and one-cycle press pulse
module btn_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  logic s1, s2, lvl, lvl_d, armed;
  logic [1:0] vld;
  logic [CW-1:0] cnt;
  // armed blocks a button still held through reset from pressing until it is seen released
  always_ff @(posedge clk) begin
    if (reset) begin
      {s1, s2, lvl, lvl_d, armed, press} <= '0;
      vld <= '0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      vld <= {vld[0], 1'b1};
      lvl_d <= lvl;
      press <= lvl & ~lvl_d & armed;
      armed <= armed | (vld[1] & ~s2 & ~lvl);
      if (s2 == lvl) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-driven run/pause/lap sequencer and display source select for the timer
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_ss,
  input  logic         btn_lap,
  input  logic         btn_clr,
  input  logic [W-1:0] th_in,
  input  logic [W-1:0] tm_in,
  input  logic [W-1:0] ts_in,
  output logic         tmr_ss,
  output logic         tmr_reset,
  output logic [W-1:0] disp_h,
  output logic [W-1:0] disp_m,
  output logic [W-1:0] disp_s,
  output logic         running,
  output logic         frozen
);
  logic p_ss, p_lap, p_clr, ss_nxt, rst_nxt;
  logic [1:0] state, nxt;
  logic [3*W-1:0] latch, latch_nxt, live;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss  (.clk(clk), .reset(reset), .btn(btn_ss),  .press(p_ss));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (.clk(clk), .reset(reset), .btn(btn_lap), .press(p_lap));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (.clk(clk), .reset(reset), .btn(btn_clr), .press(p_clr));
  // clr wins over ss, ss over lap; losers in the same cycle are dropped
  always_comb begin
    live = {th_in, tm_in, ts_in};
    nxt = state;
    latch_nxt = latch;
    ss_nxt = 1'b0;
    rst_nxt = 1'b0;
    if (p_clr) begin
      nxt = S_IDLE;
      rst_nxt = 1'b1;
      latch_nxt = state == S_LAP ? '0 : latch;
    end else if (p_ss) begin
      ss_nxt = 1'b1;
      nxt = (state == S_IDLE || state == S_PAUSE) ? S_RUN : S_PAUSE;
    end else if (p_lap && state == S_RUN) begin
      nxt = S_LAP;
      latch_nxt = live;
    end else if (p_lap && state == S_LAP) nxt = S_RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      latch <= '0;
      {tmr_ss, tmr_reset, running, frozen} <= '0;
      {disp_h, disp_m, disp_s} <= '0;
    end else begin
      state <= nxt;
      latch <= latch_nxt;
      tmr_ss <= ss_nxt;
      tmr_reset <= rst_nxt;
      {disp_h, disp_m, disp_s} <= nxt == S_LAP ? latch_nxt : live;
      running <= nxt == S_RUN || nxt == S_LAP;
      frozen <= nxt == S_LAP;
    end
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random button stimulus against a sample-window reference model
module tb_stopwatch_ctrl;
  localparam int D = 4;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, LAP = 3;
  logic clk = 1'b0, reset = 1'b1, btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
  logic [7:0] th_in = '0, tm_in = '0, ts_in = '0, disp_h, disp_m, disp_s;
  logic tmr_ss, tmr_reset, running, frozen;
  int checks = 0, failures = 0, tcount = 0, ss_seen = 0, rst_seen = 0, frz_seen = 0, ss_at = 0;
  bit hist[3][$];
  bit lvl[3], armed[3], up[3], pq[3];
  int n = 0, st = IDLE;
  logic [23:0] latch = '0, m_disp = '0;
  bit m_tss = 0, m_trs = 0, m_run = 0, m_frz = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .W(8)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .th_in(th_in), .tm_in(tm_in), .ts_in(ts_in), .tmr_ss(tmr_ss), .tmr_reset(tmr_reset),
    .disp_h(disp_h), .disp_m(disp_m), .disp_s(disp_s), .running(running), .frozen(frozen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit raw(input int b);
    return b == 0 ? btn_ss : b == 1 ? btn_lap : btn_clr;
  endfunction

  // synchronized view of button b at post-reset edge j: the raw sample two edges earlier
  function automatic bit u(input int b, input int j);
    return j >= 3 ? hist[b][j-3] : 1'b0;
  endfunction

  task automatic model_edge();
    logic [23:0] live;
    bit p[3];
    bit stable;
    live = {th_in, tm_in, ts_in};
    if (reset) begin
      n = 0; st = IDLE; latch = '0; m_disp = '0;
      {m_tss, m_trs, m_run, m_frz} = '0;
      for (int b = 0; b < 3; b++) begin
        hist[b].delete();
        {lvl[b], armed[b], up[b], pq[b]} = '0;
      end
      return;
    end
    p = pq;
    m_tss = 0; m_trs = 0;
    if (p[2]) begin
      m_trs = 1;
      if (st == LAP) latch = '0;
      st = IDLE;
    end else if (p[0]) begin
      m_tss = 1;
      st = (st == IDLE || st == PAUSE) ? RUN : PAUSE;
    end else if (p[1]) begin
      if (st == RUN) begin st = LAP; latch = live; end
      else if (st == LAP) st = RUN;
    end
    m_disp = st == LAP ? latch : live;
    m_run = st == RUN || st == LAP;
    m_frz = st == LAP;
    n++;
    for (int b = 0; b < 3; b++) begin
      hist[b].push_back(raw(b));
      pq[b] = up[b] & armed[b];
      stable = 1;
      for (int i = 0; i < D; i++) if (u(b, n - i) == lvl[b]) stable = 0;
      if (n >= 3 && !u(b, n) && !lvl[b]) armed[b] = 1;
      up[b] = stable && !lvl[b];
      if (stable) lvl[b] = !lvl[b];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    tcount++;
    chk("tmr_ss", 32'(tmr_ss), 32'(m_tss));
    chk("tmr_reset", 32'(tmr_reset), 32'(m_trs));
    chk("running", 32'(running), 32'(m_run));
    chk("frozen", 32'(frozen), 32'(m_frz));
    chk("disp", 32'({disp_h, disp_m, disp_s}), 32'(m_disp));
    if (tmr_ss) begin ss_seen++; ss_at = tcount; end
    if (tmr_reset) rst_seen++;
    if (frozen) frz_seen++;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic press(input bit s, input bit l, input bit c, input int len);
    {btn_ss, btn_lap, btn_clr} = {s, l, c};
    ticks(len);
    {btn_ss, btn_lap, btn_clr} = 3'b000;
    ticks(5);
  endtask

  initial begin
    int start;
    ticks(3);
    chk("reset_out", 32'({tmr_ss, tmr_reset, running, frozen, disp_h, disp_m, disp_s}), 32'd0);
    reset = 1'b0;
    ticks(4);
    ss_seen = 0;
    btn_ss = 1'b1;
    ticks(3);
    btn_ss = 1'b0;
    ticks(10);
    chk("glitch_ss", 32'(ss_seen), 32'd0);
    chk("glitch_run", 32'(running), 32'd0);
    ss_seen = 0;
    start = tcount + 1;
    btn_ss = 1'b1;
    ticks(20);
    btn_ss = 1'b0;
    ticks(8);
    chk("hold_count", 32'(ss_seen), 32'd1);
    chk("hold_latency", 32'(ss_at - start), 32'd7);
    chk("hold_run", 32'(running), 32'd1);
    {th_in, tm_in, ts_in} = {8'd0, 8'd1, 8'd5};
    press(0, 1, 0, 6);
    chk("lap_frozen", 32'(frozen), 32'd1);
    {th_in, tm_in, ts_in} = {8'd0, 8'd2, 8'd0};
    ticks(3);
    chk("lap_hold_disp", 32'({disp_h, disp_m, disp_s}), 32'h000105);
    press(0, 1, 0, 6);
    chk("lap_live_disp", 32'({disp_h, disp_m, disp_s}), 32'h000200);
    chk("lap_unfrozen", 32'(frozen), 32'd0);
    ss_seen = 0; rst_seen = 0;
    press(1, 0, 1, 6);
    chk("prio_ss", 32'(ss_seen), 32'd0);
    chk("prio_rst", 32'(rst_seen), 32'd1);
    chk("prio_run", 32'(running), 32'd0);
    press(1, 0, 0, 6);
    press(1, 0, 0, 6);
    chk("pause_run", 32'(running), 32'd0);
    frz_seen = 0;
    press(0, 1, 0, 6);
    chk("pause_lap", 32'(frz_seen), 32'd0);
    ss_seen = 0;
    press(1, 0, 0, 6);
    chk("pause_ss", 32'(ss_seen), 32'd1);
    chk("pause_resume", 32'(running), 32'd1);
    btn_lap = 1'b1;
    ticks(10);
    chk("lap_entered", 32'(frozen), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midhold_reset", 32'({tmr_ss, tmr_reset, running, frozen, disp_h, disp_m, disp_s}), 32'd0);
    ticks(4);
    btn_ss = 1'b1;
    ticks(6);
    btn_ss = 1'b0;
    frz_seen = 0;
    ticks(20);
    chk("held_no_pulse", 32'(frz_seen), 32'd0);
    chk("held_running", 32'(running), 32'd1);
    btn_lap = 1'b0;
    ticks(8);
    press(0, 1, 0, 6);
    chk("repress_lap", 32'(frozen), 32'd1);
    for (int it = 0; it < 300; it++) begin
      int len, gap;
      len = $urandom_range(1, 8);
      gap = $urandom_range(2, 12);
      if ($urandom_range(0, 39) == 0) reset = 1'b1;
      {btn_ss, btn_lap, btn_clr} = 3'($urandom_range(0, 7));
      for (int i = 0; i < len + gap; i++) begin
        {th_in, tm_in, ts_in} = 24'($urandom);
        if (i == len) {btn_ss, btn_lap, btn_clr} = 3'b000;
        tick();
        reset = 1'b0;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
